// File: rtl/bridge_tx_buffered.sv
// Buffered bus-response to UART byte-stream encoder: queues read responses and emits "M<hex>\r\n" frames.
// Optional `BRIDGE_TX_WRITE_ACK_EN: write responses are also queued and sent as "M\r\n".
module bridge_tx_buffered #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int NDIG   = DATA_WIDTH / 4;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int DIG_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DIG  = 3'd2;
  localparam logic [2:0] S_CR   = 3'd3;
  localparam logic [2:0] S_LF   = 3'd4;

  // Each entry is {data, rw}; rw selects whether the hex digits are sent.
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;
  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic [DIG_W-1:0]      dig_q, dig_d;

  logic                  push_type;
  logic                  push;
  logic                  drop;
  logic                  pop;
  logic                  empty;
  logic [DATA_WIDTH:0]   head;
  logic [3:0]            nib;
  logic [7:0]            hex;
  logic [7:0]            data_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_type = rw_i;
`ifdef BRIDGE_TX_WRITE_ACK_EN
    push_type = 1'b1;
`endif
    // Acceptance looks only at the registered full flag, so a same-cycle pop never frees a slot for a push.
    push  = valid_i & push_type & ready_q;
    drop  = valid_i & push_type & ~ready_q;
    empty = (count_q == '0);
    pop   = ~empty & ((state_q == S_IDLE) | ((state_q == S_LF) & ready_i));
    head  = mem[rd_ptr_q];

    state_d = state_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    dig_d   = dig_q;

    case (state_q)
      S_IDLE: if (pop) state_d = S_PRE;
      S_PRE: begin
        if (ready_i) begin
          state_d = rw_q ? S_DIG : S_CR;
          dig_d   = DIG_W'(NDIG - 1);
        end
      end
      S_DIG: begin
        if (ready_i) begin
          shift_d = shift_q << 4;
          if (dig_q == '0) state_d = S_CR;
          else             dig_d   = dig_q - DIG_W'(1);
        end
      end
      S_CR:  if (ready_i) state_d = S_LF;
      S_LF:  if (ready_i) state_d = pop ? S_PRE : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = head[DATA_WIDTH:1];
      rw_d    = head[0];
    end

    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = (count_d != CW'(FIFO_DEPTH));
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q | drop;

    // Digits are always taken from the top nibble; the shift register walks MS to LS.
    nib = shift_q[DATA_WIDTH-1 -: 4];
    hex = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

    data_d = 8'h00;
    case (state_q)
      S_PRE:   data_d = 8'h4D;
      S_DIG:   data_d = hex;
      S_CR:    data_d = 8'h0D;
      S_LF:    data_d = 8'h0A;
      default: data_d = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      dig_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      dig_q    <= dig_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {rdata_i, rw_i};
  end

  assign data_o     = data_d;
  assign valid_o    = (state_q != S_IDLE);
  assign ready_o    = ready_q;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_bridge_tx_buffered.sv
// Scoreboard bench for bridge_tx_buffered: frame-level reference model, byte scoreboard, 32-bit directed check.
module tb_bridge_tx_buffered;

  localparam int DW    = 16;
  localparam int NDIG  = DW / 4;
  localparam int DEPTH = 4;
`ifdef BRIDGE_TX_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rdata_i = '0;
  logic          rw_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic          overflow_o;
  logic          busy_o;

  logic [31:0]   rdata32 = '0;
  logic          valid32 = 1'b0;
  logic          ready32_o;
  logic [7:0]    data32_o;
  logic          valid32_o;
  logic          overflow32_o;
  logic          busy32_o;

  always #5 clk = ~clk;

  bridge_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  bridge_tx_buffered #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .rst(rst), .rdata_i(rdata32), .rw_i(1'b1), .valid_i(valid32),
    .ready_o(ready32_o), .data_o(data32_o), .valid_o(valid32_o), .ready_i(1'b1),
    .overflow_o(overflow32_o), .busy_o(busy32_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame content straight from the framing rule: 'M', hex digits (reads only), CR, LF.
  function automatic int frame_len(input logic rw);
    return rw ? NDIG + 3 : 3;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [DW-1:0] d, input logic rw, input int idx);
    int nd;
    logic [3:0] nibv;
    nd = rw ? NDIG : 0;
    if (idx == 0) return 8'h4D;
    if (idx <= nd) begin
      nibv = 4'((d >> (4 * (NDIG - idx))) & 16'hF);
      return (nibv < 4'd10) ? 8'h30 + {4'h0, nibv} : 8'h41 + {4'h0, nibv} - 8'd10;
    end
    if (idx == nd + 1) return 8'h0D;
    return 8'h0A;
  endfunction

  typedef struct { logic [DW-1:0] d; logic rw; } ent_t;

  ent_t       m_q[$];
  logic [7:0] sb[$];
  ent_t       cur;
  int         cur_len = 0;
  int         cur_idx = 0;
  bit         m_ovf = 1'b0;
  bit         started = 1'b0;

  // Reference model: checks the present outputs, then advances across the coming clock edge.
  always @(negedge clk) begin
    int  left;
    int  size_pre;
    bit  hs;
    bit  do_pop;
    left = cur_len - cur_idx;
    if (started) begin
      check("valid_o", valid_o, left > 0);
      check("ready_o", ready_o, m_q.size() != DEPTH);
      check("overflow_o", overflow_o, m_ovf);
      check("busy_o", busy_o, (left > 0) || (m_q.size() > 0));
      check("data_o", data_o, (left > 0) ? frame_byte(cur.d, cur.rw, cur_idx) : 8'h00);
    end
    if (rst) begin
      m_q.delete();
      sb.delete();
      cur_len = 0;
      cur_idx = 0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else begin
      hs       = (left > 0) && ready_i;
      size_pre = m_q.size();
      do_pop   = (size_pre > 0) && ((left == 0) || (hs && left == 1));
      if (hs) cur_idx++;
      if (do_pop) begin
        cur     = m_q.pop_front();
        cur_idx = 0;
        cur_len = frame_len(cur.rw);
      end
      if (valid_i && (rw_i || WACK)) begin
        if (size_pre < DEPTH) begin
          m_q.push_back('{d: rdata_i, rw: rw_i});
          for (int i = 0; i < frame_len(rw_i); i++) sb.push_back(frame_byte(rdata_i, rw_i, i));
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Byte monitor: every accepted byte is matched against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && valid_o === 1'b1 && ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", data_o, 8'hFF);
      end else begin
        exp_b = sb.pop_front();
        check("sb_byte", data_o, exp_b);
      end
    end
  end

  logic [7:0] got32[$];
  always @(negedge clk) begin
    if (!rst && valid32_o === 1'b1) got32.push_back(data32_o);
  end

  task automatic cyc(input logic r, input logic v, input logic w, input logic [DW-1:0] d, input logic rd);
    rst = r; valid_i = v; rw_i = w; rdata_i = d; ready_i = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, rd);
  endtask

  logic [7:0] exp32 [11];

  initial begin
    exp32 = '{8'h4D, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Single read, UART always ready; also launches the 32-bit instance.
    valid32 = 1'b1; rdata32 = 32'hDEADBEEF;
    cyc(1'b0, 1'b1, 1'b1, 16'h0123, 1'b1);
    valid32 = 1'b0; rdata32 = '0;
    idle(14, 1'b1);

    // Back-to-back reads with a slow UART: ready_i pulses once every 10 cycles.
    cyc(1'b0, 1'b1, 1'b1, 16'h4567, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h89AB, 1'b0);
    for (int i = 0; i < 160; i++) cyc(1'b0, 1'b0, 1'b0, '0, (i % 10) == 9);
    idle(4, 1'b1);

    // Write response: acked only when the write-ack feature is built in.
    cyc(1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1);
    idle(10, 1'b1);

    // Fill with the UART stalled, then overflow with a sixth read.
    cyc(1'b0, 1'b1, 1'b1, 16'hCDEF, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h2222, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h3333, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h4444, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
    idle(3, 1'b0);
    idle(45, 1'b1);
    check("fifo_drained", sb.size(), 0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    cyc(1'b0, 1'b1, 1'b1, 16'hCDEF, 1'b1);
    idle(4, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0001, 1'b1);
    idle(12, 1'b1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++)
      cyc(1'b0, $urandom_range(0, 99) < 30, $urandom_range(0, 3) != 0,
          DW'($urandom), $urandom_range(0, 99) < 60);
    idle(60, 1'b1);
    check("all_bytes_out", sb.size(), 0);

    check("dw32_len", got32.size(), 11);
    for (int i = 0; i < 11; i++)
      check($sformatf("dw32_byte%0d", i), (i < got32.size()) ? got32[i] : 8'hXX, exp32[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
